// File: rtl/sigmadelta_adc_mc.sv
// Multi-channel sigma-delta ADC back end: per-channel window accumulators, a boxcar decimation
// filter, and a banked result serializer with ready/valid handshake and overrun detection.
module sigmadelta_adc_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned ADC_WIDTH      = 8,
  parameter int unsigned ACCUM_BITS     = 10,
  parameter int unsigned LPF_DEPTH_BITS = 3,
  parameter int unsigned INPUT_TOPOLOGY = 0,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    analog_cmp,
  output logic [NUM_CH-1:0]    analog_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [ADC_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 overrun,
  input  logic                 clear_ovr
);

  localparam int unsigned SUM_W = ADC_WIDTH + LPF_DEPTH_BITS;

  typedef enum logic {StIdle, StSend} state_e;

  // Window / frame sequencing
  logic [ACCUM_BITS-1:0]     win_q;
  logic [LPF_DEPTH_BITS-1:0] lpf_q;
  logic                      win_end;
  logic                      frame_end;
  logic                      load_q;

  // Per-channel datapath
  logic [ACCUM_BITS-1:0] acc_q   [NUM_CH];
  logic [ACCUM_BITS-1:0] acc_inc [NUM_CH];
  logic [ADC_WIDTH-1:0]  raw     [NUM_CH];
  logic [SUM_W-1:0]      sum_q   [NUM_CH];
  logic [SUM_W-1:0]      sum_add [NUM_CH];
  logic [ADC_WIDTH-1:0]  filt_d  [NUM_CH];
  logic [ADC_WIDTH-1:0]  filt_q  [NUM_CH];
  logic [ADC_WIDTH-1:0]  bank_q  [NUM_CH];

  // Serializer
  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d, pend_after;
  logic                overrun_q, overrun_d;
  logic                ovr_set;
  logic [CH_W-1:0]     ch_sel;
  logic                xfer;

  assign win_end   = en && (win_q == '1);
  assign frame_end = win_end && (lpf_q == '1);

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      acc_inc[i] = (acc_q[i] == '1) ? acc_q[i] : acc_q[i] + ACCUM_BITS'(analog_out[i]);
      raw[i]     = acc_inc[i][ACCUM_BITS-1 -: ADC_WIDTH];
      sum_add[i] = sum_q[i] + SUM_W'(raw[i]);
      // Dropping the low LPF_DEPTH_BITS bits is the truncating divide by the frame length.
      filt_d[i]  = (INPUT_TOPOLOGY == 1) ? ~sum_add[i][SUM_W-1:LPF_DEPTH_BITS]
                                         :  sum_add[i][SUM_W-1:LPF_DEPTH_BITS];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      analog_out <= '0;
      win_q      <= '0;
      lpf_q      <= '0;
      load_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        acc_q[i]  <= '0;
        sum_q[i]  <= '0;
        filt_q[i] <= '0;
        bank_q[i] <= '0;
      end
    end else begin
      analog_out <= analog_cmp;
      load_q     <= frame_end;
      if (en) begin
        win_q <= win_q + ACCUM_BITS'(1);
        for (int i = 0; i < int'(NUM_CH); i++) begin
          acc_q[i] <= win_end ? '0 : acc_inc[i];
        end
      end
      if (win_end) begin
        lpf_q <= lpf_q + LPF_DEPTH_BITS'(1);
        for (int i = 0; i < int'(NUM_CH); i++) begin
          sum_q[i] <= frame_end ? '0 : sum_add[i];
        end
      end
      if (frame_end) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          filt_q[i] <= filt_d[i];
        end
      end
      if (load_q) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          bank_q[i] <= filt_q[i];
        end
      end
    end
  end

  // Lowest pending channel wins; scan from the top so the last hit is the lowest index.
  always_comb begin
    ch_sel = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        ch_sel = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ovr_set    = 1'b0;
    out_valid  = (state_q == StSend);
    xfer       = out_valid && out_ready;
    pend_after = pending_q;
    if (xfer) begin
      pend_after[ch_sel] = 1'b0;
    end
    pending_d = pend_after;
    unique case (state_q)
      StIdle: begin
        if (load_q) begin
          state_d   = StSend;
          pending_d = '1;
        end
      end
      StSend: begin
        if (load_q) begin
          // A fresh bank replaces whatever is left; only unsent beats count as an overrun.
          pending_d = '1;
          ovr_set   = |pend_after;
        end else if (pend_after == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    overrun_d = ovr_set ? 1'b1 : (clear_ovr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    out_ch   = out_valid ? ch_sel : '0;
    out_data = out_valid ? bank_q[ch_sel] : '0;
    out_last = out_valid && (ch_sel == CH_W'(NUM_CH - 1));
    overrun  = overrun_q;
  end

endmodule

// File: tb/tb_sigmadelta_adc_mc.sv
// Scoreboard bench for sigmadelta_adc_mc: a window/frame arithmetic model predicts every beat
// and frame start; a negedge monitor compares what the DUT presents.
module tb_sigmadelta_adc_mc;

  localparam int NCH   = 3;
  localparam int W     = 6;
  localparam int A     = 8;
  localparam int L     = 2;
  localparam int TOPO  = 0;
  localparam int CHW   = 2;
  localparam int WIN   = 1 << A;
  localparam int NWIN  = 1 << L;
  localparam int FRAME = WIN * NWIN;
  localparam int ACC_MAX   = WIN - 1;
  localparam int RAW_SHIFT = A - W;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic [NCH-1:0] cmp = '0;
  logic [NCH-1:0] analog_out;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [CHW-1:0] out_ch;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           overrun;
  logic           clear_ovr = 1'b0;

  sigmadelta_adc_mc #(
    .NUM_CH        (NCH),
    .ADC_WIDTH     (W),
    .ACCUM_BITS    (A),
    .LPF_DEPTH_BITS(L),
    .INPUT_TOPOLOGY(TOPO)
  ) dut (
    .clk_in    (clk),
    .rstn      (rstn),
    .en        (en),
    .analog_cmp(cmp),
    .analog_out(analog_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_last  (out_last),
    .overrun   (overrun),
    .clear_ovr (clear_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
    bit last;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state
  logic [NCH-1:0] fb;
  int    ones[NCH];
  int    raw_sum[NCH];
  int    last_frame[NCH];
  int    pos = 0;
  int    fidx = 0;
  bit    sb_on = 1'b1;
  beat_t exp_q[$];
  int    start_q[$];

  // Monitor state
  bit             prev_valid = 1'b0;
  bit             stall_prev = 1'b0;
  logic [CHW-1:0] held_ch;
  logic [W-1:0]   held_data;
  int             last_seen[NCH];

  // Stimulus modes
  int             cmp_mode = 0;
  logic [NCH-1:0] cmp_const = '0;
  bit             tog = 1'b0;
  bit             rand_en = 1'b0;
  bit             rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Reference: count feedback ones per window of enabled cycles, saturate, keep the top bits,
  // average NWIN windows.
  task automatic model_step();
    cyc++;
    if (!rstn) begin
      fb   = '0;
      pos  = 0;
      fidx = 0;
      for (int c = 0; c < NCH; c++) begin
        ones[c]    = 0;
        raw_sum[c] = 0;
      end
      exp_q.delete();
      start_q.delete();
      return;
    end
    if (en) begin
      for (int c = 0; c < NCH; c++) ones[c] += int'(fb[c]);
      if (pos == WIN - 1) begin
        for (int c = 0; c < NCH; c++) begin
          int cnt;
          cnt = (ones[c] > ACC_MAX) ? ACC_MAX : ones[c];
          raw_sum[c] += cnt >> RAW_SHIFT;
          ones[c] = 0;
        end
        if (fidx == NWIN - 1) begin
          for (int c = 0; c < NCH; c++) begin
            beat_t b;
            int    avg;
            avg = raw_sum[c] / NWIN;
            if (TOPO == 1) avg = (1 << W) - 1 - avg;
            last_frame[c] = avg;
            raw_sum[c]    = 0;
            b.ch   = c;
            b.data = avg;
            b.last = (c == NCH - 1);
            if (sb_on) exp_q.push_back(b);
          end
          if (sb_on) start_q.push_back(cyc + 1);
          fidx = 0;
        end else begin
          fidx++;
        end
        pos = 0;
      end else begin
        pos++;
      end
    end
    fb = cmp;
  endtask

  task automatic mon_step();
    if (sb_on) begin
      if (out_valid && !prev_valid) begin
        if (start_q.size() == 0) fail("frame_start_unexpected");
        else chk("frame_start_cycle", cyc, start_q.pop_front());
      end
      if (stall_prev && out_valid) begin
        chk("hold_ch", out_ch, held_ch);
        chk("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("beat_unexpected");
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_ch", out_ch, b.ch);
          chk("beat_data", out_data, b.data);
          chk("beat_last", out_last, b.last);
          last_seen[out_ch] = int'(out_data);
        end
      end
    end
    prev_valid = out_valid;
    stall_prev = out_valid && !out_ready;
    held_ch    = out_ch;
    held_data  = out_data;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (cmp_mode)
      1: begin
        cmp    = cmp_const;
        cmp[0] = tog;
        tog    = ~tog;
      end
      2: cmp = NCH'($urandom);
      default: cmp = cmp_const;
    endcase
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (rand_en) en = ($urandom_range(0, 15) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int v_cyc;
    int r;
    logic [CHW-1:0] c0;
    logic [W-1:0]   d0;
    for (int c = 0; c < NCH; c++) last_seen[c] = -1;

    // Reset state
    step(3);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_analog_out", analog_out, 0);

    // Constant comparator inputs
    step(1);
    cmp_const = 3'b101;
    en        = 1'b1;
    out_ready = 1'b1;
    step(3 * FRAME + 20);
    chk("const_ch0_full", last_seen[0], (1 << W) - 1);
    chk("const_ch1_zero", last_seen[1], 0);
    chk("const_ch2_full", last_seen[2], (1 << W) - 1);

    // ch0 toggling, with a 100-cycle enable gap mid-window
    cmp_mode = 1;
    step(300);
    en = 1'b0;
    step(100);
    en = 1'b1;
    step(3 * FRAME);
    chk("toggle_ch0_half", last_seen[0], 1 << (W - 1));
    chk("toggle_ch2_full", last_seen[2], (1 << W) - 1);

    // Random inputs, enable and back-pressure
    cmp_mode   = 2;
    rand_en    = 1'b1;
    rand_ready = 1'b1;
    step(5 * FRAME);
    rand_en    = 1'b0;
    rand_ready = 1'b0;
    en         = 1'b1;
    out_ready  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 200);
    chk("drain_beats_left", exp_q.size(), 0);
    chk("drain_frames_left", start_q.size(), 0);

    // Overrun: consumer stalls for more than a frame
    step(1);
    sb_on     = 1'b0;
    rstn      = 1'b0;
    out_ready = 1'b0;
    step(1);
    rstn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 2 * FRAME + 10);
    if (!out_valid) begin
      fail("ovr_first_valid_timeout");
    end else begin
      v_cyc = cyc;
      c0    = out_ch;
      d0    = out_data;
      chk("ovr_first_ch", out_ch, 0);
      chk("ovr_first_data", out_data, last_frame[0]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!overrun) begin
          chk("ovr_hold_ch", out_ch, c0);
          chk("ovr_hold_data", out_data, d0);
        end
      end while (!overrun && n < FRAME + 10);
      if (!overrun) begin
        fail("ovr_set_timeout");
      end else begin
        chk("ovr_interval", cyc - v_cyc, FRAME);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_restart_ch", out_ch, 0);
        chk("ovr_new_data", out_data, last_frame[0]);
      end
      repeat (5) @(negedge clk);
      chk("ovr_sticky", overrun, 1);
      step(1);
      clear_ovr = 1'b1;
      step(1);
      clear_ovr = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", overrun, 0);
    end

    // Reset in the middle of SEND
    chk("pre_reset_valid", out_valid, 1);
    step(1);
    rstn = 1'b0;
    step(1);
    r         = cyc;
    rstn      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_analog_out", analog_out, 0);
    n = 0;
    while (!out_valid && n < FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      fail("midrst_frame_timeout");
    end else begin
      chk("midrst_frame_cycle", cyc - r, FRAME + 1);
      chk("midrst_frame_ch", out_ch, 0);
      chk("midrst_frame_data", out_data, last_frame[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
